aer_in_frontend: RTL
====================

Name: aer_in_frontend

Overview:
- Input stage directly upstream of the event controller.
- Receives address-events from off-chip over an asynchronous 4-phase bundled-data AER handshake and synchronises the request into CLK.
- Buffers events in a small FIFO.
- Presents events to the controller's AERIN_ADDR/AERIN_REQ/AERIN_ACK port. The controller acknowledges with a single-cycle pulse and reads the address in the cycle after that pulse.

Parameters:
- M, 8, neuron address width; event word is 2*M+1 bits.
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2.
- SYNC_STAGES, 2, flip-flop stages on the external request; ≥2.

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-high reset.
- EXT_ADDR  input  2*M+1  off-chip event address; bundled data, stable while EXT_REQ is high.
- EXT_REQ  input  1  off-chip request; asynchronous to CLK.
- EXT_ACK  output  1  off-chip acknowledge; registered.
- CORE_ADDR  output  2*M+1  event presented to the controller; registered.
- CORE_REQ  output  1  event-valid request to the controller; registered.
- CORE_ACK  input  1  single-cycle acknowledge from the controller.
- FIFO_LEVEL  output  $clog2(DEPTH)+1  number of stored entries.
- FIFO_FULL  output  1  FIFO_LEVEL == DEPTH.
- FIFO_EMPTY  output  1  FIFO_LEVEL == 0.

Behaviour:
- Reset is asynchronous and active-high; clock is CLK.
- Reset values:
  - EXT_ACK=0, CORE_REQ=0, CORE_ADDR=0.
  - Read/write pointers 0, FIFO_LEVEL=0, FIFO_EMPTY=1, FIFO_FULL=0.
  - Sync chain 0; both FSMs in their idle state.
- req_s is the SYNC_STAGES-deep synchronised EXT_REQ. EXT_ADDR is sampled only in the push cycle, which is at least SYNC_STAGES cycles after the EXT_REQ rise.
- External FSM (E_IDLE, E_ACK):
  - E_IDLE: if req_s=1 and FIFO_FULL=0, write EXT_ADDR at the write pointer, increment it, set EXT_ACK<=1, go to E_ACK.
  - E_IDLE, req_s=1 and FIFO full: stall with EXT_ACK=0; the push happens in the first cycle FIFO_FULL reads 0.
  - E_ACK: when req_s=0, set EXT_ACK<=0 and go to E_IDLE. Otherwise hold.
  - Exactly one push per 4-phase cycle.
- Core FSM (C_IDLE, C_REQ, C_HOLD):
  - C_IDLE: if FIFO_EMPTY=0, load CORE_ADDR<=FIFO head, set CORE_REQ<=1, go to C_REQ.
  - C_REQ: on CORE_ACK=1, set CORE_REQ<=0, pop (increment the read pointer), go to C_HOLD.
  - C_HOLD: unconditionally go to C_IDLE.
  - CORE_ADDR changes only on a C_IDLE load. It is therefore stable from the CORE_REQ rise through the cycle after the ACK, which is when the controller decodes it.
  - CORE_REQ is low for at least 2 cycles between events.
  - CORE_ACK outside C_REQ is ignored; no pop occurs.
- FIFO:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - FIFO_LEVEL is a registered counter: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - Full and empty are evaluated on the current cycle's registered state. A pop does not enable a push in the same cycle, and there is no fall-through: a push into an empty FIFO produces CORE_REQ=1 two edges later (push edge, then load edge).
  - No entry is ever dropped or overwritten; back-pressure goes to the sender via the withheld EXT_ACK.
- Latency: EXT_REQ rise to CORE_REQ rise is SYNC_STAGES+2 cycles when the FIFO is empty and the core FSM is idle.
- Reset mid-operation: all FIFO contents are discarded and EXT_ACK falls immediately. A sender still holding EXT_REQ high after reset is treated as a new request and is pushed again.

Test Plan:
- Single event: EXT_ADDR=0x1_0305, EXT_REQ rise; controller model acks 1 cycle after CORE_REQ -> EXT_ACK rises 3 cycles after the EXT_REQ rise. CORE_REQ rises 4 cycles after the EXT_REQ rise with CORE_ADDR=0x1_0305, held through the cycle after CORE_ACK. FIFO_LEVEL returns to 0.
- Back-pressure: CORE_ACK held low, send 5 events (DEPTH=4) -> 4 are acked and FIFO_FULL=1. The 5th EXT_ACK stays 0 until the first CORE_ACK. All 5 addresses are delivered in order afterwards.
- Wrap-around: stream 10 events with random ack delay of 1–5 cycles -> all delivered in order, pointers wrap twice, FIFO_LEVEL never exceeds 4.
- Simultaneous push and pop at level 2 -> FIFO_LEVEL stays 2. At level 4, a pop in the same cycle as a pending request -> the push occurs the next cycle.
- Spurious CORE_ACK while CORE_REQ=0 -> FIFO_LEVEL unchanged, no address lost.
- RST asserted in E_ACK with 3 entries queued -> EXT_ACK=0, CORE_REQ=0, FIFO_EMPTY=1 immediately. With EXT_REQ still high after release, the address is re-pushed SYNC_STAGES+1 cycles later.

Source files
------------

// File: rtl/aer_in_frontend.sv
// AER input front end: 4-phase receiver with request synchroniser,
// small FIFO, and a single-cycle-ack handshake toward the controller.
module aer_in_frontend #(
  parameter int M           = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [2*M:0]           EXT_ADDR,
  input  logic                   EXT_REQ,
  output logic                   EXT_ACK,
  output logic [2*M:0]           CORE_ADDR,
  output logic                   CORE_REQ,
  input  logic                   CORE_ACK,
  output logic [$clog2(DEPTH):0] FIFO_LEVEL,
  output logic                   FIFO_FULL,
  output logic                   FIFO_EMPTY
);

  localparam int W  = 2*M+1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW+1;

  typedef enum logic {
    E_IDLE,
    E_ACK
  } e_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_REQ,
    C_HOLD
  } c_state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  e_state_t e_state_q, e_state_d;
  c_state_t c_state_q, c_state_d;

  logic          ext_ack_q, ext_ack_d;
  logic          core_req_q, core_req_d;
  logic [W-1:0]  core_addr_q, core_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  mem_q [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign req_s = sync_q[SYNC_STAGES-1];
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // Sender side: one push per 4-phase cycle, ack withheld while full
  always_comb begin
    e_state_d = e_state_q;
    ext_ack_d = ext_ack_q;
    push      = 1'b0;
    unique case (e_state_q)
      E_IDLE: begin
        if (req_s && !full) begin
          push      = 1'b1;
          ext_ack_d = 1'b1;
          e_state_d = E_ACK;
        end
      end
      E_ACK: begin
        if (!req_s) begin
          ext_ack_d = 1'b0;
          e_state_d = E_IDLE;
        end
      end
    endcase
  end

  // Controller side: address is only reloaded from C_IDLE
  always_comb begin
    c_state_d   = c_state_q;
    core_req_d  = core_req_q;
    core_addr_d = core_addr_q;
    pop         = 1'b0;
    unique case (c_state_q)
      C_IDLE: begin
        if (!empty) begin
          core_addr_d = mem_q[rd_ptr_q];
          core_req_d  = 1'b1;
          c_state_d   = C_REQ;
        end
      end
      C_REQ: begin
        if (CORE_ACK) begin
          core_req_d = 1'b0;
          pop        = 1'b1;
          c_state_d  = C_HOLD;
        end
      end
      C_HOLD: begin
        c_state_d = C_IDLE;
      end
      default: begin
        core_req_d = 1'b0;
        c_state_d  = C_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q      <= '0;
      e_state_q   <= E_IDLE;
      c_state_q   <= C_IDLE;
      ext_ack_q   <= 1'b0;
      core_req_q  <= 1'b0;
      core_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], EXT_REQ};
      e_state_q   <= e_state_d;
      c_state_q   <= c_state_d;
      ext_ack_q   <= ext_ack_d;
      core_req_q  <= core_req_d;
      core_addr_q <= core_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= EXT_ADDR;
    end
  end

  assign EXT_ACK    = ext_ack_q;
  assign CORE_REQ   = core_req_q;
  assign CORE_ADDR  = core_addr_q;
  assign FIFO_LEVEL = level_q;
  assign FIFO_FULL  = full;
  assign FIFO_EMPTY = empty;

endmodule
